// File: rtl/display_pkg.sv
// Shared types and default raster timing for the ping-pong display controller.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      SCAN   = 2'd2,
      VBLANK = 2'd3
   } state_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_TOTAL  = 800;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_TOTAL  = 525;
   localparam int DEF_CNT_W    = 10;
   localparam int DEF_ADDR_W   = 19;

   function automatic logic [1:0] buf_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   // Lowest-index set bit wins; zero in gives zero out.
   function automatic logic [1:0] lowest_set(input logic [1:0] v);
      return v[0] ? 2'b01 : (v[1] ? 2'b10 : 2'b00);
   endfunction

endpackage

// File: rtl/raster_timer.sv
// Pixel/line counters with active-window and sync decode; clr_i holds both counters at zero.
module raster_timer #(
   parameter int H_ACTIVE = 640,
   parameter int H_TOTAL  = 800,
   parameter int V_ACTIVE = 480,
   parameter int V_TOTAL  = 525,
   parameter int CNT_W    = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             run_i,
   output logic [CNT_W-1:0] px_o,
   output logic [CNT_W-1:0] line_o,
   output logic             active_o,
   output logic             sync_hb_o,
   output logic             sync_vb_o,
   output logic             vb_next_o,
   output logic             frame_end_o
);

   logic [CNT_W-1:0] px_q, px_d, line_q, line_d;
   logic             px_wrap;

   always_comb begin
      px_wrap = (px_q == CNT_W'(H_TOTAL - 1));
      px_d    = px_q;
      line_d  = line_q;
      if (clr_i) begin
         px_d   = '0;
         line_d = '0;
      end else if (run_i) begin
         px_d = px_wrap ? '0 : px_q + CNT_W'(1);
         if (px_wrap)
            line_d = (line_q == CNT_W'(V_TOTAL - 1)) ? '0 : line_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         px_q   <= '0;
         line_q <= '0;
      end else begin
         px_q   <= px_d;
         line_q <= line_d;
      end
   end

   assign px_o        = px_q;
   assign line_o      = line_q;
   assign active_o    = (px_q < CNT_W'(H_ACTIVE)) && (line_q < CNT_W'(V_ACTIVE));
   assign sync_hb_o   = run_i && (px_q == CNT_W'(H_ACTIVE));
   assign sync_vb_o   = run_i && (px_q == '0) && (line_q == CNT_W'(V_ACTIVE));
   // Last cycle of the active frame: the next edge lands on vertical blank.
   assign vb_next_o   = px_wrap && (line_q == CNT_W'(V_ACTIVE - 1));
   assign frame_end_o = px_wrap && (line_q == CNT_W'(V_TOTAL - 1));

endmodule

// File: rtl/display_pingpong_ctrl.sv
// Ping-pong display controller: raster sequencing FSM, two-buffer ownership flags and
// read-address generation. Buffers swap on the edge that enters vertical blank.
module display_pingpong_ctrl
   import display_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_TOTAL  = DEF_H_TOTAL,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_TOTAL  = DEF_V_TOTAL,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int ADDR_W   = DEF_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cs_display_i,
   input  logic              fill_done_i,
   input  logic              fill_buf_i,
   output logic [1:0]        wr_en_o,
   output logic [1:0]        rd_en_o,
   output logic [1:0]        sel_buf_o,
   output logic              sel_blank_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic [CNT_W-1:0]  px_cnt_o,
   output logic [CNT_W-1:0]  line_cnt_o,
   output logic              sync_hb_o,
   output logic              sync_vb_o,
   output logic [1:0]        buf_empty_o,
   output logic              frame_repeat_o,
   output logic              fill_err_o,
   output state_t            state_o
);

   state_t            state_q, state_d;
   logic              disp_q, disp_d;
   logic [1:0]        empty_q, empty_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              frep_q, frep_d, ferr_q, ferr_d;
   logic              running, active, vb_next, frame_end, fill_ok, other_full;
   logic [1:0]        wr_pool;

   assign running = (state_q == SCAN) || (state_q == VBLANK);

   raster_timer #(
      .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE),
      .V_TOTAL(V_TOTAL), .CNT_W(CNT_W)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (!running || !cs_display_i),
      .run_i      (running),
      .px_o       (px_cnt_o),
      .line_o     (line_cnt_o),
      .active_o   (active),
      .sync_hb_o  (sync_hb_o),
      .sync_vb_o  (sync_vb_o),
      .vb_next_o  (vb_next),
      .frame_end_o(frame_end)
   );

   always_comb begin
      state_d = state_q;
      disp_d  = disp_q;
      empty_d = empty_q;
      addr_d  = addr_q;
      frep_d  = 1'b0;
      ferr_d  = 1'b0;
      // Outside SCAN/VBLANK nothing is on screen, so either buffer may be filled.
      fill_ok = fill_done_i && empty_q[fill_buf_i] && !(running && (fill_buf_i == disp_q));
      if (fill_done_i) begin
         if (fill_ok) empty_d[fill_buf_i] = 1'b0;
         else         ferr_d = 1'b1;
      end
      // Read after the fill update so a fill landing on the swap edge still counts.
      other_full = !empty_d[~disp_q];

      if (!cs_display_i) begin
         state_d = IDLE;
         addr_d  = '0;
      end else begin
         case (state_q)
            IDLE:  state_d = PRIME;
            PRIME: begin
               if (empty_q != 2'b11) begin
                  disp_d  = empty_q[0];
                  state_d = SCAN;
               end
            end
            SCAN: begin
               if (active)
                  addr_d = (addr_q == ADDR_W'(H_ACTIVE * V_ACTIVE - 1)) ? '0 : addr_q + ADDR_W'(1);
               if (vb_next) begin
                  state_d = VBLANK;
                  addr_d  = '0;
                  if (other_full) begin
                     empty_d[disp_q] = 1'b1;
                     disp_d          = ~disp_q;
                  end else begin
                     frep_d = 1'b1;
                  end
               end
            end
            VBLANK: if (frame_end) state_d = SCAN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         disp_q  <= 1'b0;
         empty_q <= 2'b11;
         addr_q  <= '0;
         frep_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         disp_q  <= disp_d;
         empty_q <= empty_d;
         addr_q  <= addr_d;
         frep_q  <= frep_d;
         ferr_q  <= ferr_d;
      end
   end

   assign wr_pool        = (state_q == IDLE) ? 2'b00 :
                           running ? (empty_q & ~buf_onehot(disp_q)) : empty_q;
   assign wr_en_o        = lowest_set(wr_pool);
   assign rd_en_o        = (state_q == SCAN && active) ? buf_onehot(disp_q) : 2'b00;
   assign sel_buf_o      = buf_onehot(disp_q);
   assign sel_blank_o    = !(state_q == SCAN && active);
   assign rd_addr_o      = addr_q;
   assign buf_empty_o    = empty_q;
   assign frame_repeat_o = frep_q;
   assign fill_err_o     = ferr_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_display_pingpong_ctrl.sv
// Directed bench for display_pingpong_ctrl on a 6x5 raster (4x3 visible); expected
// output snapshots are queued per cycle by the driver and checked by a separate monitor.
module tb_display_pingpong_ctrl;
   import display_pkg::*;

   localparam int HA = 4, HT = 6, VA = 3, VT = 5;
   localparam int CW = 10, AW = 19;

   typedef struct packed {
      state_t        st;
      logic [1:0]    wr;
      logic [1:0]    rd;
      logic [1:0]    sel;
      logic          blank;
      logic [CW-1:0] px;
      logic [CW-1:0] ln;
      logic [AW-1:0] addr;
      logic          hb;
      logic          vb;
      logic [1:0]    empty;
      logic          fr;
      logic          ferr;
   } obs_t;

   logic clk, rst_n, cs, fd, fb;
   logic [1:0] wr_en, rd_en, sel_buf, buf_empty;
   logic sel_blank, sync_hb, sync_vb, frame_repeat, fill_err;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] px_cnt, line_cnt;
   state_t state;

   obs_t  exp_q[$];
   string tag_q[$];
   int    cyc_q[$];
   int    cyc = 0;
   int    n_cmp = 0, n_fail = 0;

   display_pingpong_ctrl #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .CNT_W(CW), .ADDR_W(AW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .cs_display_i(cs), .fill_done_i(fd), .fill_buf_i(fb),
      .wr_en_o(wr_en), .rd_en_o(rd_en), .sel_buf_o(sel_buf), .sel_blank_o(sel_blank),
      .rd_addr_o(rd_addr), .px_cnt_o(px_cnt), .line_cnt_o(line_cnt),
      .sync_hb_o(sync_hb), .sync_vb_o(sync_vb), .buf_empty_o(buf_empty),
      .frame_repeat_o(frame_repeat), .fill_err_o(fill_err), .state_o(state)
   );

   // Clock and cycle count
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Expected outputs while counters are held (IDLE, PRIME, reset).
   function automatic obs_t exp_still(input state_t st, input logic d, input logic [1:0] emp);
      obs_t e;
      e.st = st;  e.sel = d ? 2'b10 : 2'b01;  e.empty = emp;
      e.wr = 2'b00;
      if (st == PRIME) e.wr = emp[0] ? 2'b01 : (emp[1] ? 2'b10 : 2'b00);
      e.rd = 2'b00;  e.blank = 1'b1;  e.px = '0;  e.ln = '0;  e.addr = '0;
      e.hb = 1'b0;  e.vb = 1'b0;  e.fr = 1'b0;  e.ferr = 1'b0;
      return e;
   endfunction

   // Expected outputs at frame position t (0..29) while scanning.
   function automatic obs_t exp_run(input int t, input logic d, input logic [1:0] emp,
                                    input logic fr, input logic fe);
      obs_t e;
      int px, ln;
      logic act;
      logic [1:0] pool;
      px  = t % HT;
      ln  = t / HT;
      act = (px < HA) && (ln < VA);
      e.st    = (ln < VA) ? SCAN : VBLANK;
      e.sel   = d ? 2'b10 : 2'b01;
      e.empty = emp;
      pool    = emp & ~e.sel;
      e.wr    = pool[0] ? 2'b01 : (pool[1] ? 2'b10 : 2'b00);
      e.rd    = act ? e.sel : 2'b00;
      e.blank = !act;
      e.px    = CW'(px);
      e.ln    = CW'(ln);
      e.addr  = (ln < VA) ? AW'((ln * HA + ((px < HA) ? px : HA)) % (HA * VA)) : '0;
      e.hb    = (px == HA);
      e.vb    = (t == VA * HT);
      e.fr    = fr;
      e.ferr  = fe;
      return e;
   endfunction

   // Driver: queue the expectation for the current cycle, then advance one clock.
   task automatic step(input string tag, input obs_t e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      cyc_q.push_back(cyc);
      @(posedge clk);
      #1;
   endtask

   // Monitor / scoreboard
   initial begin
      obs_t got, e;
      string tg;
      forever begin
         @(negedge clk);
         while (cyc_q.size() > 0 && cyc_q[0] < cyc) begin
            tg = tag_q.pop_front();
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
            n_cmp++;
            n_fail++;
            $display("FAIL %s: expectation not sampled by cycle %0d", tg, cyc);
         end
         if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            void'(cyc_q.pop_front());
            got = '{st: state, wr: wr_en, rd: rd_en, sel: sel_buf, blank: sel_blank,
                    px: px_cnt, ln: line_cnt, addr: rd_addr, hb: sync_hb, vb: sync_vb,
                    empty: buf_empty, fr: frame_repeat, ferr: fill_err};
            n_cmp++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL %s cyc=%0d got=%p required=%p", tg, cyc, got, e);
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic       e_disp;
      logic [1:0] e_empty;
      rst_n = 1'b0; cs = 1'b0; fd = 1'b0; fb = 1'b0;
      @(posedge clk);
      #1;
      step("reset", exp_still(IDLE, 1'b0, 2'b11));
      step("reset", exp_still(IDLE, 1'b0, 2'b11));
      rst_n = 1'b1;
      cs    = 1'b1;
      step("idle_go", exp_still(IDLE, 1'b0, 2'b11));
      for (int i = 0; i < 3; i++) step("prime_wait", exp_still(PRIME, 1'b0, 2'b11));
      fd = 1'b1; fb = 1'b0;
      step("prime_fill", exp_still(PRIME, 1'b0, 2'b11));
      fd = 1'b0;
      step("prime_full", exp_still(PRIME, 1'b0, 2'b10));

      // Frame 1: fill buf1 mid-frame, two illegal fills, swap at vertical blank
      e_disp = 1'b0; e_empty = 2'b10;
      for (int t = 0; t < HT * VT; t++) begin
         fd = (t == 8) || (t == 12) || (t == 14);
         fb = (t != 12);
         if (t == 9) e_empty = 2'b00;
         if (t == 18) begin e_disp = 1'b1; e_empty = 2'b01; end
         step("frame1", exp_run(t, e_disp, e_empty, 1'b0, (t == 13) || (t == 15)));
      end
      fd = 1'b0;

      // Frame 2: no refill, so the frame repeats
      for (int t = 0; t < HT * VT; t++)
         step("frame2", exp_run(t, 1'b1, 2'b01, t == 18, 1'b0));

      // Frame 3: fill arrives on the swap-decision cycle
      e_disp = 1'b1; e_empty = 2'b01;
      for (int t = 0; t < HT * VT; t++) begin
         fd = (t == 17);
         fb = 1'b0;
         if (t == 18) begin e_disp = 1'b0; e_empty = 2'b10; end
         step("frame3", exp_run(t, e_disp, e_empty, 1'b0, 1'b0));
      end
      fd = 1'b0;

      // Display disable mid-scan, then re-enable
      for (int t = 0; t < 4; t++) begin
         cs = (t != 3);
         step("cs_scan", exp_run(t, 1'b0, 2'b10, 1'b0, 1'b0));
      end
      step("cs_idle", exp_still(IDLE, 1'b0, 2'b10));
      cs = 1'b1;
      step("cs_idle", exp_still(IDLE, 1'b0, 2'b10));
      step("reprime", exp_still(PRIME, 1'b0, 2'b10));
      for (int t = 0; t < 5; t++) step("rescan", exp_run(t, 1'b0, 2'b10, 1'b0, 1'b0));

      // Reset asserted between clock edges
      rst_n = 1'b0;
      step("async_rst", exp_still(IDLE, 1'b0, 2'b11));
      step("async_rst", exp_still(IDLE, 1'b0, 2'b11));

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_cmp++;
      n_fail++;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
